// File: rtl/ch_readout_master.sv
// ch_readout_master: serial readout master for one PSEC channel counter port.
// Walks SELECT_REG through 0..NUM_REGS-1, clocks DATA_W bits out of the
// channel on SPI_CLK (MSB first on CNT_SER) and presents each word to
// downstream logic over a valid/ready handshake.
// Optional build macro CH_RDOUT_LOAD_PULSE_EN: issue one extra SPI_CLK pulse
// after SETUP to load the channel's parallel shift register before the data
// bits; CNT_SER is not sampled during that pulse.
module ch_readout_master #(
  parameter int DATA_W    = 10,
  parameter int NUM_REGS  = 6,
  parameter int CLK_DIV   = 4,
  parameter int SETUP_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              INST_READOUT,
  output logic [2:0]        SELECT_REG,
  output logic              SPI_CLK,
  input  logic              CNT_SER,
  output logic [DATA_W-1:0] WORD_DATA,
  output logic [2:0]        WORD_SEL,
  output logic              WORD_VALID,
  input  logic              WORD_READY
);

  localparam int CYC_MAX = (CLK_DIV > SETUP_CYC) ? CLK_DIV : SETUP_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W + 1);

`ifdef CH_RDOUT_LOAD_PULSE_EN
  localparam logic LOAD_EN = 1'b1;
`else
  localparam logic LOAD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CLK_HI, S_CLK_LO, S_EMIT, S_FINISH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CYC_W-1:0]   r_cyc;
  logic [BIT_W-1:0]   r_bit;
  logic [DATA_W-1:0]  r_shift;
  logic [2:0]         r_sel;
  logic               r_load;
  logic               w_cyc_last;
  logic               w_sample;
  logic               w_hs;
  logic               w_last_reg;

  assign w_last_reg = (r_sel == 3'(NUM_REGS - 1));

  // State register; RST aborts any readout without producing DONE.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and Moore outputs derived from the current state.
  always_comb begin
    w_state_nxt  = r_state;
    w_cyc_last   = 1'b0;
    w_sample     = 1'b0;
    w_hs         = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    INST_READOUT = 1'b0;
    SPI_CLK      = 1'b0;
    WORD_VALID   = 1'b0;
    WORD_DATA    = '0;
    WORD_SEL     = '0;
    SELECT_REG   = r_sel;
    case (r_state)
      S_IDLE: begin
        if (START) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        BUSY         = 1'b1;
        INST_READOUT = 1'b1;
        w_cyc_last   = (r_cyc == CYC_W'(SETUP_CYC - 1));
        if (w_cyc_last) w_state_nxt = S_CLK_HI;
      end
      S_CLK_HI: begin
        BUSY         = 1'b1;
        INST_READOUT = 1'b1;
        SPI_CLK      = 1'b1;
        w_cyc_last   = (r_cyc == CYC_W'(CLK_DIV - 1));
        if (w_cyc_last) w_state_nxt = S_CLK_LO;
      end
      S_CLK_LO: begin
        BUSY         = 1'b1;
        INST_READOUT = 1'b1;
        w_cyc_last   = (r_cyc == CYC_W'(CLK_DIV - 1));
        if (w_cyc_last) begin
          // The load pulse (if any) shifts nothing and does not count as a bit.
          w_sample = ~r_load;
          if (!r_load && (r_bit == BIT_W'(DATA_W - 1))) w_state_nxt = S_EMIT;
          else                                          w_state_nxt = S_CLK_HI;
        end
      end
      S_EMIT: begin
        BUSY         = 1'b1;
        INST_READOUT = 1'b1;
        WORD_VALID   = 1'b1;
        WORD_DATA    = r_shift;
        WORD_SEL     = r_sel;
        w_hs         = WORD_READY;
        if (WORD_READY) w_state_nxt = w_last_reg ? S_FINISH : S_SETUP;
      end
      S_FINISH: begin
        DONE        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Phase timer, bit counter, deserialiser and register-select counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sel   <= '0;
      r_load  <= 1'b0;
    end else begin
      // Timer restarts on every state change, so it never needs to wrap.
      if ((w_state_nxt == r_state) &&
          ((r_state == S_SETUP) || (r_state == S_CLK_HI) || (r_state == S_CLK_LO)))
        r_cyc <= r_cyc + 1'b1;
      else
        r_cyc <= '0;
      case (r_state)
        S_IDLE: begin
          if (START) r_sel <= '0;
        end
        S_SETUP: begin
          r_bit   <= '0;
          r_shift <= '0;
          r_load  <= LOAD_EN;
        end
        S_CLK_LO: begin
          if (w_cyc_last) begin
            r_load <= 1'b0;
            if (w_sample) begin
              r_shift <= {r_shift[DATA_W-2:0], CNT_SER};
              r_bit   <= r_bit + 1'b1;
            end
          end
        end
        S_EMIT: begin
          // Select returns to 0 after the last register so IDLE shows 0.
          if (w_hs) r_sel <= w_last_reg ? 3'd0 : r_sel + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ch_readout_master.md
Name: ch_readout_master

Overview:
- Controller-side serial readout master for one PSEC channel's counter readout interface.
- Drives INST_READOUT, SELECT_REG and SPI_CLK into the channel, and deserialises the channel's CNT_SER bit stream into parallel words.
- Reads registers 0..NUM_REGS-1 in order and hands each word to downstream logic (event builder / FIFO) over a valid/ready handshake.

Parameters:
- DATA_W, 10: bits per serial word (counter width).
- NUM_REGS, 6: number of SELECT_REG values read per readout (0 = trigger count, 1..5 = CA..CE).
- CLK_DIV, 4: SPI_CLK half-period in CLK cycles; legal values are 1 and above.
- SETUP_CYC, 2: CLK cycles SELECT_REG is held stable before the first SPI_CLK rising edge of each word; legal values are 1 and above.

Ports:
- CLK  in  1  system clock; the only clock in the block.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle request to begin a full readout; ignored unless idle.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse when the last word has been accepted.
- INST_READOUT  out  1  readout enable to the channel.
- SELECT_REG  out  3  register select to the channel.
- SPI_CLK  out  1  serial clock to the channel; idles low.
- CNT_SER  in  1  serial data from the channel, MSB first.
- WORD_DATA  out  DATA_W  deserialised word.
- WORD_SEL  out  3  SELECT_REG value that WORD_DATA was read from.
- WORD_VALID  out  1  WORD_DATA/WORD_SEL are valid.
- WORD_READY  in  1  downstream accepts the word.

Behaviour:
- Reset: every output is 0, the state is IDLE, and all counters and the shift register are 0. RST in any state aborts the readout at the next edge; no DONE is produced.
- States: IDLE, SETUP, CLK_HI, CLK_LO, EMIT, FINISH.
- IDLE:
  - START=1 at edge E0 sets INST_READOUT=1, BUSY=1, SELECT_REG=0 and moves to SETUP.
- SETUP:
  - Held for SETUP_CYC cycles, with SPI_CLK=0 and SELECT_REG stable.
  - The bit counter and shift register are cleared.
  - Then moves to CLK_HI.
- CLK_HI:
  - SPI_CLK=1 for CLK_DIV cycles, then moves to CLK_LO. The channel shifts its next bit on this rising edge.
- CLK_LO:
  - SPI_CLK=0 for CLK_DIV cycles.
  - On the last cycle, CNT_SER is shifted into the shift register LSB (shift left), so the first bit ends up as the MSB.
  - Bit counter increments. If the count reaches DATA_W, moves to EMIT; otherwise moves to CLK_HI.
- EMIT:
  - WORD_VALID=1, WORD_DATA = shift register, WORD_SEL = SELECT_REG. SPI_CLK is held low.
  - Outputs stay stable while WORD_READY=0, with unlimited backpressure and no bits lost.
  - On the cycle where WORD_VALID and WORD_READY are both high:
    - WORD_VALID drops.
    - If SELECT_REG = NUM_REGS-1, moves to FINISH.
    - Otherwise SELECT_REG increments and the block moves to SETUP.
- FINISH:
  - Lasts one cycle. INST_READOUT=0, BUSY=0, DONE=1.
  - Then moves to IDLE.
- Timing:
  - SPI_CLK first rises at E0+SETUP_CYC.
  - WORD_VALID for word 0 first rises at E0+SETUP_CYC+2·CLK_DIV·DATA_W, which is E0+82 with the defaults.
  - After each handshake, the next word's WORD_VALID rises SETUP_CYC+2·CLK_DIV·DATA_W cycles later.
- START while BUSY is ignored. START in the same cycle as RST is ignored.
- Exactly DATA_W SPI_CLK rising edges are produced per word, and none are produced while in EMIT, SETUP, FINISH or IDLE.
- SELECT_REG changes only on the edge that leaves EMIT, never while SPI_CLK=1.
- Counter widths hold CLK_DIV, SETUP_CYC and DATA_W without wrap; the select counter never exceeds NUM_REGS-1.

Optional Feature:
- Macro: CH_RDOUT_LOAD_PULSE_EN.
- Defined:
  - After SETUP, one extra SPI_CLK pulse (CLK_DIV high, CLK_DIV low) is issued before the data bits. It loads the channel's parallel shift register, and CNT_SER is not sampled during it.
  - Per-word latency grows by 2·CLK_DIV, so word 0 WORD_VALID rises at E0+90 with the defaults.
  - SPI_CLK rising edges per word are DATA_W+1.
- Undefined: no load pulse is issued, and the behaviour is exactly as described above.

Test Plan:
- Reset, then idle 20 cycles -> all outputs 0, SPI_CLK never toggles.
- START with the responder model serving words 0x005, 0x2A5, 0x3FF, 0x000, 0x155, 0x1C3 and WORD_READY=1 -> six words with WORD_SEL 0..5 and exactly those WORD_DATA values. First WORD_VALID at E0+82 (E0+90 with the macro). DONE pulses once, and INST_READOUT falls in the same cycle as DONE.
- WORD_READY held 0 for 50 cycles on word 2 -> WORD_VALID and WORD_DATA=0x3FF held stable, SPI_CLK low, SELECT_REG=2 throughout, and the remaining words are correct afterwards.
- START pulsed again mid-readout (during word 3) -> ignored, still exactly 6 words and 1 DONE.
- RST asserted during CLK_HI of word 1 bit 4 -> the next cycle all outputs are 0 and there is no DONE. A following START reads all 6 words correctly.
- CLK_DIV=1, SETUP_CYC=1 -> SPI_CLK toggles every cycle, word 0 WORD_VALID at E0+21, and data matches the model.
